// File: rtl/gol_pkg.sv
// Shared defaults, row-index width and FSM state encoding for the row window reader.
package gol_pkg;

  localparam int unsigned ROW_LENGTH_DEF   = 1280;
  localparam int unsigned NUM_ROWS_DEF     = 720;
  localparam int unsigned ADDR_W_DEF       = 10;
  localparam int unsigned BRAM_LATENCY_DEF = 1;

  // Width of a row index (matches the BRAM row address)
  localparam int unsigned ROW_IDX_W = ADDR_W_DEF;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
  localparam logic [STATE_W-1:0] ST_PRIME_REQ  = 4'd1;
  localparam logic [STATE_W-1:0] ST_PRIME_WAIT = 4'd2;
  localparam logic [STATE_W-1:0] ST_RD_REQ     = 4'd3;
  localparam logic [STATE_W-1:0] ST_RD_WAIT    = 4'd4;
  localparam logic [STATE_W-1:0] ST_CAPTURE    = 4'd5;
  localparam logic [STATE_W-1:0] ST_EMIT       = 4'd6;
  localparam logic [STATE_W-1:0] ST_HOLD       = 4'd7;
  localparam logic [STATE_W-1:0] ST_DONE       = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = ST_IDLE,
    S_PRIME_REQ  = ST_PRIME_REQ,
    S_PRIME_WAIT = ST_PRIME_WAIT,
    S_RD_REQ     = ST_RD_REQ,
    S_RD_WAIT    = ST_RD_WAIT,
    S_CAPTURE    = ST_CAPTURE,
    S_EMIT       = ST_EMIT,
    S_HOLD       = ST_HOLD,
    S_DONE       = ST_DONE
  } rwr_state_e;

endpackage

// File: rtl/row_window_regs.sv
// Three-row window storage (top/middle/bottom) with load, shift and zero controls.
module row_window_regs
  import gol_pkg::*;
#(
  parameter int unsigned ROW_LENGTH = ROW_LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load_top,
  input  logic                  load_mid,
  input  logic                  load_bot,
  input  logic                  zero_bot,
  input  logic                  shift,
  input  logic [ROW_LENGTH-1:0] rd_data,
  output logic [ROW_LENGTH-1:0] top_row,
  output logic [ROW_LENGTH-1:0] middle_row,
  output logic [ROW_LENGTH-1:0] bottom_row
);

  // Window registers; a shift moves the window down by one row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_row    <= '0;
      middle_row <= '0;
      bottom_row <= '0;
    end else if (clear) begin
      top_row    <= '0;
      middle_row <= '0;
      bottom_row <= '0;
    end else begin
      if (load_top)      top_row <= rd_data;
      else if (shift)    top_row <= middle_row;

      if (load_mid)      middle_row <= rd_data;
      else if (shift)    middle_row <= bottom_row;

      if (load_bot)      bottom_row <= rd_data;
      else if (zero_bot) bottom_row <= '0;
    end
  end

endmodule

// File: rtl/row_window_reader.sv
// Frame sequencer: reads the source BRAM row by row and presents 3-row windows
// to the next-state engine. Optional macro TORUS_WRAP_EN enables vertical wrap.
module row_window_reader
  import gol_pkg::*;
#(
  parameter int unsigned ROW_LENGTH   = ROW_LENGTH_DEF,
  parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF,
  parameter int unsigned ADDR_W       = ROW_IDX_W,
  parameter int unsigned BRAM_LATENCY = BRAM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [ROW_LENGTH-1:0] rd_data,
  output logic [ROW_LENGTH-1:0] top_row,
  output logic [ROW_LENGTH-1:0] middle_row,
  output logic [ROW_LENGTH-1:0] bottom_row,
  output logic [ADDR_W-1:0]     calc_row,
  output logic                  calc_flg,
  output logic                  valid_set
);

  localparam int unsigned WAIT_W = (BRAM_LATENCY > 2) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW       = ADDR_W'(NUM_ROWS - 1);
  localparam logic [WAIT_W-1:0] PRIME_WAIT_INI = WAIT_W'(BRAM_LATENCY - 1);
  localparam logic [WAIT_W-1:0] RD_WAIT_INI    = WAIT_W'((BRAM_LATENCY > 1) ? BRAM_LATENCY - 2 : 0);

`ifdef TORUS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  rwr_state_e        state, state_d;
  logic [ADDR_W-1:0] row, row_d, row_next;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              prime_top, prime_top_d;
  logic              rd_en_d, busy_d, done_d, valid_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              clear, load_top, load_mid, load_bot, zero_bot, shift;

  assign row_next = row + ADDR_W'(1);
  assign calc_row = row;
  assign calc_flg = busy;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      wait_cnt  <= '0;
      prime_top <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_set <= 1'b0;
    end else begin
      state     <= state_d;
      row       <= row_d;
      wait_cnt  <= wait_d;
      prime_top <= prime_top_d;
      rd_en     <= rd_en_d;
      rd_addr   <= rd_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      valid_set <= valid_d;
    end
  end

  // Next-state logic; output values are computed for the state being entered.
  always_comb begin
    state_d     = state;
    row_d       = row;
    wait_d      = wait_cnt;
    prime_top_d = prime_top;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr;
    busy_d      = busy;
    done_d      = 1'b0;
    valid_d     = 1'b0;
    clear       = 1'b0;
    load_top    = 1'b0;
    load_mid    = 1'b0;
    load_bot    = 1'b0;
    zero_bot    = 1'b0;
    shift       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PRIME_REQ;
          busy_d      = 1'b1;
          row_d       = '0;
          clear       = 1'b1;
          prime_top_d = WRAP;
          rd_en_d     = 1'b1;
          rd_addr_d   = WRAP ? LAST_ROW : '0;
        end
      end
      S_PRIME_REQ: begin
        state_d = S_PRIME_WAIT;
        wait_d  = PRIME_WAIT_INI;
      end
      S_PRIME_WAIT: begin
        // Last cycle here is the rd_data-valid cycle of the priming read.
        if (wait_cnt != '0) begin
          wait_d = wait_cnt - WAIT_W'(1);
        end else if (prime_top) begin
          load_top    = 1'b1;
          prime_top_d = 1'b0;
          state_d     = S_PRIME_REQ;
          rd_en_d     = 1'b1;
          rd_addr_d   = '0;
        end else begin
          load_mid  = 1'b1;
          state_d   = S_RD_REQ;
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_W'(1);
        end
      end
      S_RD_REQ: begin
        if (BRAM_LATENCY > 1) begin
          state_d = S_RD_WAIT;
          wait_d  = RD_WAIT_INI;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_RD_WAIT: begin
        if (wait_cnt != '0) wait_d  = wait_cnt - WAIT_W'(1);
        else                state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        load_bot = 1'b1;
        state_d  = S_EMIT;
        valid_d  = 1'b1;
      end
      S_EMIT: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (row == LAST_ROW) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          shift = 1'b1;
          row_d = row_next;
          if (row_next == LAST_ROW && !WRAP) begin
            zero_bot = 1'b1;
            state_d  = S_EMIT;
            valid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            rd_en_d   = 1'b1;
            rd_addr_d = (row_next == LAST_ROW) ? '0 : row_next + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  row_window_regs #(
    .ROW_LENGTH (ROW_LENGTH)
  ) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load_top   (load_top),
    .load_mid   (load_mid),
    .load_bot   (load_bot),
    .zero_bot   (zero_bot),
    .shift      (shift),
    .rd_data    (rd_data),
    .top_row    (top_row),
    .middle_row (middle_row),
    .bottom_row (bottom_row)
  );

endmodule

// File: tb/tb_row_window_reader.sv
// Directed bench for row_window_reader: BRAM latency 1 and 3 instances, held start,
// asynchronous mid-frame reset and a glider generation through an engine model.
module tb_row_window_reader;

  localparam int unsigned RL = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 2;
  localparam logic [RL-1:0] RA = 8'hA1;
  localparam logic [RL-1:0] RB = 8'hB2;
  localparam logic [RL-1:0] RC = 8'hC3;
  localparam logic [RL-1:0] RD = 8'hD4;

`ifdef TORUS_WRAP_EN
  localparam int NRD = 6;
  int exp_rd_adr [NRD]   = '{3, 0, 1, 2, 3, 0};
  int exp_rd_cyc [2][NRD] = '{'{1, 3, 5, 9, 13, 17}, '{1, 5, 9, 15, 21, 27}};
  int exp_v_cyc  [2][4]  = '{'{7, 11, 15, 19}, '{13, 19, 25, 31}};
  int exp_done   [2]     = '{21, 33};
  logic [RL-1:0] exp_top [4] = '{RD, RA, RB, RC};
  logic [RL-1:0] exp_bot [4] = '{RB, RC, RD, RA};
  logic [RL-1:0] gold    [4] = '{8'h00, 8'h05, 8'h06, 8'h05};
`else
  localparam int NRD = 4;
  int exp_rd_adr [NRD]   = '{0, 1, 2, 3};
  int exp_rd_cyc [2][NRD] = '{'{1, 3, 7, 11}, '{1, 5, 11, 17}};
  int exp_v_cyc  [2][4]  = '{'{5, 9, 13, 15}, '{9, 15, 21, 23}};
  int exp_done   [2]     = '{17, 25};
  logic [RL-1:0] exp_top [4] = '{8'h00, RA, RB, RC};
  logic [RL-1:0] exp_bot [4] = '{RB, RC, RD, 8'h00};
  logic [RL-1:0] gold    [4] = '{8'h00, 8'h05, 8'h06, 8'h02};
`endif
  logic [RL-1:0] exp_mid [4] = '{RA, RB, RC, RD};
  logic [RL-1:0] glider  [4] = '{8'h02, 8'h04, 8'h07, 8'h00};

  logic          clk, rst_n;
  logic          start [2], busy [2], done [2], rd_en [2], calc_flg [2], valid_set [2];
  logic [AW-1:0] rd_addr [2], calc_row [2];
  logic [RL-1:0] rd_data [2], top_row [2], middle_row [2], bottom_row [2];

  logic [RL-1:0] mem [2][NR];
  logic [RL-1:0] pipe1, pipe2;
  logic [RL-1:0] dest [NR];
  logic          eng_we;
  logic [AW-1:0] eng_wa;
  logic [RL-1:0] eng_wd;

  int n_vec, n_miss, tick;
  int t0 [2];
  int n_rd [2], n_v [2], n_done [2];
  int rd_cyc [2][16], rd_adr [2][16];
  int v_cyc [2][16], v_row [2][16], v_top [2][16], v_mid [2][16], v_bot [2][16], v_flg [2][16];
  int done_cyc [2][4], done_busy [2][4];

  row_window_reader #(.ROW_LENGTH(RL), .NUM_ROWS(NR), .ADDR_W(AW), .BRAM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .top_row(top_row[0]), .middle_row(middle_row[0]), .bottom_row(bottom_row[0]),
    .calc_row(calc_row[0]), .calc_flg(calc_flg[0]), .valid_set(valid_set[0])
  );

  row_window_reader #(.ROW_LENGTH(RL), .NUM_ROWS(NR), .ADDR_W(AW), .BRAM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .top_row(top_row[1]), .middle_row(middle_row[1]), .bottom_row(bottom_row[1]),
    .calc_row(calc_row[1]), .calc_flg(calc_flg[1]), .valid_set(valid_set[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tick <= tick + 1;

  // Source BRAM models: latency 1 and latency 3 (data only in the valid cycle)
  always @(posedge clk) begin
    if (rd_en[0]) rd_data[0] <= mem[0][rd_addr[0]];
    pipe1      <= rd_en[1] ? mem[1][rd_addr[1]] : '0;
    pipe2      <= pipe1;
    rd_data[1] <= pipe2;
  end

  function automatic int bit_at(input logic [RL-1:0] v, input int i);
    if (i < 0 || i >= int'(RL)) return 0;
    return int'(v[i]);
  endfunction

  // Conway next state for the middle row, dead horizontal edges
  function automatic logic [RL-1:0] life_row(input logic [RL-1:0] t, input logic [RL-1:0] m,
                                             input logic [RL-1:0] b);
    logic [RL-1:0] n;
    n = '0;
    for (int c = 0; c < int'(RL); c++) begin
      int cnt;
      cnt = bit_at(m, c - 1) + bit_at(m, c + 1);
      for (int dc = -1; dc <= 1; dc++) cnt += bit_at(t, c + dc) + bit_at(b, c + dc);
      n[c] = (cnt == 3) || (cnt == 2 && m[c]);
    end
    return n;
  endfunction

  // Engine model: registers write address/enable on valid_set, commits a cycle later
  always @(posedge clk) begin
    eng_we <= valid_set[0];
    eng_wa <= calc_row[0];
    eng_wd <= life_row(top_row[0], middle_row[0], bottom_row[0]);
    if (eng_we) dest[eng_wa] <= eng_wd;
  end

  // Event logger, sampled mid-cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d] === 1'b1 && n_rd[d] < 16) begin
        rd_cyc[d][n_rd[d]] = tick - t0[d];
        rd_adr[d][n_rd[d]] = int'(rd_addr[d]);
        n_rd[d]++;
      end
      if (valid_set[d] === 1'b1 && n_v[d] < 16) begin
        v_cyc[d][n_v[d]] = tick - t0[d];
        v_row[d][n_v[d]] = int'(calc_row[d]);
        v_top[d][n_v[d]] = int'(top_row[d]);
        v_mid[d][n_v[d]] = int'(middle_row[d]);
        v_bot[d][n_v[d]] = int'(bottom_row[d]);
        v_flg[d][n_v[d]] = int'(busy[d] & calc_flg[d]);
        n_v[d]++;
      end
      if (done[d] === 1'b1 && n_done[d] < 4) begin
        done_cyc[d][n_done[d]]  = tick - t0[d];
        done_busy[d][n_done[d]] = int'(busy[d] | calc_flg[d]);
        n_done[d]++;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs(input int d);
    n_rd[d] = 0;
    n_v[d] = 0;
    n_done[d] = 0;
  endtask

  task automatic start_frame(input int d, input bit hold);
    @(posedge clk);
    #1;
    start[d] = 1'b1;
    t0[d] = tick;
    if (!hold) begin
      @(posedge clk);
      #1;
      start[d] = 1'b0;
    end
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int k;
    k = 0;
    while (n_done[d] < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check($sformatf("done_seen_d%0d", d), n_done[d], target);
  endtask

  task automatic check_idle(input int d, input string pfx);
    check($sformatf("%s_rd_en_d%0d", pfx, d), int'(rd_en[d]), 0);
    check($sformatf("%s_busy_d%0d", pfx, d), int'(busy[d]), 0);
    check($sformatf("%s_done_d%0d", pfx, d), int'(done[d]), 0);
    check($sformatf("%s_valid_d%0d", pfx, d), int'(valid_set[d]), 0);
    check($sformatf("%s_flg_d%0d", pfx, d), int'(calc_flg[d]), 0);
    check($sformatf("%s_addr_d%0d", pfx, d), int'(rd_addr[d]), 0);
    check($sformatf("%s_row_d%0d", pfx, d), int'(calc_row[d]), 0);
    check($sformatf("%s_top_d%0d", pfx, d), int'(top_row[d]), 0);
    check($sformatf("%s_mid_d%0d", pfx, d), int'(middle_row[d]), 0);
    check($sformatf("%s_bot_d%0d", pfx, d), int'(bottom_row[d]), 0);
  endtask

  task automatic check_frame(input int d, input int rb, input int vb, input int off, input int di);
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("d%0d_rd_cyc%0d", d, rb + k), rd_cyc[d][rb + k], exp_rd_cyc[d][k] + off);
      check($sformatf("d%0d_rd_adr%0d", d, rb + k), rd_adr[d][rb + k], exp_rd_adr[k]);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_v_cyc%0d", d, vb + k), v_cyc[d][vb + k], exp_v_cyc[d][k] + off);
      check($sformatf("d%0d_v_row%0d", d, vb + k), v_row[d][vb + k], k);
      check($sformatf("d%0d_v_top%0d", d, vb + k), v_top[d][vb + k], int'(exp_top[k]));
      check($sformatf("d%0d_v_mid%0d", d, vb + k), v_mid[d][vb + k], int'(exp_mid[k]));
      check($sformatf("d%0d_v_bot%0d", d, vb + k), v_bot[d][vb + k], int'(exp_bot[k]));
      check($sformatf("d%0d_v_busy%0d", d, vb + k), v_flg[d][vb + k], 1);
    end
    check($sformatf("d%0d_done_cyc%0d", d, di), done_cyc[d][di], exp_done[d] + off);
    check($sformatf("d%0d_done_busy%0d", d, di), done_busy[d][di], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    tick = 0;
    t0[0] = 0;
    t0[1] = 0;
    n_vec = 0;
    n_miss = 0;
    clear_logs(0);
    clear_logs(1);
    for (int r = 0; r < int'(NR); r++) begin
      mem[0][r] = exp_mid[r];
      mem[1][r] = exp_mid[r];
      dest[r] = 8'hFF;
    end

    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "rst");
    check_idle(1, "rst");
    rst_n = 1'b1;

    // Basic frame on both latencies
    start_frame(0, 1'b0);
    start_frame(1, 1'b0);
    wait_done(0, 1, 100);
    wait_done(1, 1, 100);
    repeat (3) @(posedge clk);
    check_frame(0, 0, 0, 0, 0);
    check_frame(1, 0, 0, 0, 0);
    check("d0_rd_count", n_rd[0], NRD);
    check("d1_rd_count", n_rd[1], NRD);
    check("d0_v_count", n_v[0], 4);
    check("d1_v_count", n_v[1], 4);

    // Start held high: exactly one frame per IDLE visit
    clear_logs(0);
    start_frame(0, 1'b1);
    wait_done(0, 1, 100);
    repeat (4) @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 2, 100);
    repeat (10) @(posedge clk);
    check("held_rd_count", n_rd[0], 2 * NRD);
    check("held_v_count", n_v[0], 8);
    check("held_done_count", n_done[0], 2);
    check_frame(0, 0, 0, 0, 0);
    check_frame(0, NRD, 4, exp_done[0] + 1, 1);

    // Asynchronous reset at cycle 10 of a frame
    clear_logs(0);
    start_frame(0, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle(0, "arst");
    check_idle(1, "arst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("arst_no_done", n_done[0], 0);
    clear_logs(0);
    start_frame(0, 1'b0);
    wait_done(0, 1, 100);
    repeat (3) @(posedge clk);
    check_frame(0, 0, 0, 0, 0);

    // Glider generation through the engine model
    for (int r = 0; r < int'(NR); r++) mem[0][r] = glider[r];
    clear_logs(0);
    start_frame(0, 1'b0);
    wait_done(0, 1, 100);
    repeat (3) @(posedge clk);
    for (int r = 0; r < int'(NR); r++)
      check($sformatf("glider_row%0d", r), int'(dest[r]), int'(gold[r]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
